handshake_downsize_pipe: RTL and testbench

Width-downsizing valid/ready stage that sits directly downstream of the 32-bit fully-registered handshake pipe. It accepts one IN_W-bit word and emits it as IN_W/OUT_W narrow beats on a valid/ready output, with sustained full throughput of one narrow beat per cycle. It feeds byte-wide consumers such as UART or serial TX from the 32-bit datapath.

---
 rtl/handshake_pkg.sv | 17 +
 rtl/handshake_downsize_pipe.sv | 98 +++++++++
 tb/tb_handshake_downsize_pipe.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/handshake_pkg.sv
// Shared handshake types and width helpers for the 32-bit datapath stages.
package handshake_pkg;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_SEND = 1'b1
  } hs_state_e;

  localparam int HS_DATA_W = 32;
  localparam int HS_BYTE_W = 8;

  // Beat counter width; a single-beat ratio still needs one bit.
  function automatic int hs_cnt_w(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/handshake_downsize_pipe.sv
// Splits one IN_W word into IN_W/OUT_W registered narrow beats on a valid/ready port.
// Optional slave_last output is enabled by defining HS_DOWNSIZE_LAST_EN.
module handshake_downsize_pipe
  import handshake_pkg::*;
#(
  parameter int IN_W      = HS_DATA_W,
  parameter int OUT_W     = HS_BYTE_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             master_valid,
  input  logic [IN_W-1:0]  master_data,
  output logic             master_ready,
  output logic             slave_valid,
  output logic [OUT_W-1:0] slave_data,
  input  logic             slave_ready
`ifdef HS_DOWNSIZE_LAST_EN
  ,
  output logic             slave_last
`endif
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CW    = hs_cnt_w(RATIO);
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  if (IN_W % OUT_W != 0) begin : g_bad_ratio
    $error("handshake_downsize_pipe: IN_W (%0d) must be a multiple of OUT_W (%0d)", IN_W, OUT_W);
  end

  hs_state_e       state_q, nxt_state;
  logic [IN_W-1:0] shift_q, shift_nxt;
  logic [CW-1:0]   cnt_q;
  logic            last_beat, beat_hs, load;

  assign last_beat = (cnt_q == LAST_CNT);
  assign beat_hs   = (state_q == HS_SEND) && slave_ready;
  assign load      = master_valid && master_ready;

  // Only the final-beat handshake reaches master_ready combinationally.
  assign master_ready = (state_q == HS_IDLE) || (beat_hs && last_beat);

  // Outgoing beat always sits at the register end, so no output mux.
  if (LSB_FIRST) begin : g_lsb
    assign slave_data = shift_q[OUT_W-1:0];
    assign shift_nxt  = shift_q >> OUT_W;
  end else begin : g_msb
    assign slave_data = shift_q[IN_W-1 -: OUT_W];
    assign shift_nxt  = shift_q << OUT_W;
  end

  assign slave_valid = (state_q == HS_SEND);

  always_comb begin
    nxt_state = state_q;
    case (state_q)
      HS_IDLE: if (master_valid) nxt_state = HS_SEND;
      HS_SEND: if (beat_hs && last_beat) nxt_state = master_valid ? HS_SEND : HS_IDLE;
      default: nxt_state = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HS_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= nxt_state;
      if (load) begin
        shift_q <= master_data;
        cnt_q   <= '0;
      end else if (beat_hs && !last_beat) begin
        shift_q <= shift_nxt;
        cnt_q   <= cnt_q + CW'(1);
      end
    end
  end

`ifdef HS_DOWNSIZE_LAST_EN
  logic last_q;

  // Tracks the beat that will be presented next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else if (load) begin
      last_q <= (RATIO == 1);
    end else if (beat_hs) begin
      last_q <= !last_beat && ((cnt_q + CW'(1)) == LAST_CNT);
    end
  end

  assign slave_last = last_q;
`endif

endmodule

// File: tb/tb_handshake_downsize_pipe.sv
// Scoreboard bench: LSB-first and MSB-first instances share stimulus.
module tb_handshake_downsize_pipe;

  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int RATIO = IN_W / OUT_W;
  localparam int NWORDS = 6000;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             mv = 1'b0, sr = 1'b0;
  logic [IN_W-1:0]  md = '0;
  logic             mr_l, sv_l, mr_m, sv_m;
  logic [OUT_W-1:0] sd_l, sd_m;
`ifdef HS_DOWNSIZE_LAST_EN
  logic             sl_l, sl_m;
`endif

  int checks = 0, failures = 0;
  logic [OUT_W:0] q_l[$], q_m[$];

  always #5 clk = ~clk;

  handshake_downsize_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .master_valid(mv), .master_data(md), .master_ready(mr_l),
    .slave_valid(sv_l), .slave_data(sd_l), .slave_ready(sr)
`ifdef HS_DOWNSIZE_LAST_EN
    , .slave_last(sl_l)
`endif
  );

  handshake_downsize_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .master_valid(mv), .master_data(md), .master_ready(mr_m),
    .slave_valid(sv_m), .slave_data(sd_m), .slave_ready(sr)
`ifdef HS_DOWNSIZE_LAST_EN
    , .slave_last(sl_m)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [IN_W-1:0] w);
    for (int i = 0; i < RATIO; i++) begin
      q_l.push_back({i == RATIO - 1, w[i*OUT_W +: OUT_W]});
      q_m.push_back({i == RATIO - 1, w[(RATIO-1-i)*OUT_W +: OUT_W]});
    end
  endtask

  // Monitor: sample at negedge, i.e. the values the next rising edge will see.
  initial begin
    logic             hold_l, hold_m;
    logic [OUT_W-1:0] hd_l, hd_m;
    logic [OUT_W:0]   e;
    hold_l = 1'b0; hold_m = 1'b0; hd_l = '0; hd_m = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_l = 1'b0;
        hold_m = 1'b0;
      end else begin
        if (hold_l) begin
          chk("stall_vld_l", sv_l, 1);
          chk("stall_dat_l", sd_l, hd_l);
        end
        if (hold_m) begin
          chk("stall_vld_m", sv_m, 1);
          chk("stall_dat_m", sd_m, hd_m);
        end
        if (mv && mr_l) push_word(md);
        if (sv_l && sr) begin
          if (q_l.size() == 0) chk("spurious_l", 1, 0);
          else begin
            e = q_l.pop_front();
            chk("beat_l", sd_l, e[OUT_W-1:0]);
`ifdef HS_DOWNSIZE_LAST_EN
            chk("last_l", sl_l, e[OUT_W]);
`endif
          end
        end
        if (sv_m && sr) begin
          if (q_m.size() == 0) chk("spurious_m", 1, 0);
          else begin
            e = q_m.pop_front();
            chk("beat_m", sd_m, e[OUT_W-1:0]);
`ifdef HS_DOWNSIZE_LAST_EN
            chk("last_m", sl_m, e[OUT_W]);
`endif
          end
        end
        hold_l = sv_l && !sr; hd_l = sd_l;
        hold_m = sv_m && !sr; hd_m = sd_m;
      end
    end
  end

  initial begin
    logic [7:0] e1[4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    logic [7:0] e2[8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    logic       r2[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] e4[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] e5[4] = '{8'h55, 8'h00, 8'h00, 8'h00};
    int nv, sent, cyc;
    logic acc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sv", sv_l, 0);
    chk("rst_sd", sd_l, 0);
`ifdef HS_DOWNSIZE_LAST_EN
    chk("rst_last", sl_l, 0);
`endif
    rst_n = 1'b1;
    chk("rst_mr", mr_l, 1);

    // Single word, LSB first, one-cycle latency
    sr = 1'b1; mv = 1'b1; md = 32'hA1B2C3D4;
    chk("t1_mr_idle", mr_l, 1);
    step();
    mv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_sv", sv_l, 1);
      chk("t1_sd", sd_l, e1[i]);
      chk("t1_mr", mr_l, (i == 3));
`ifdef HS_DOWNSIZE_LAST_EN
      chk("t1_last", sl_l, (i == 3));
`endif
      step();
    end
    chk("t1_idle", sv_l, 0);

    // Back-to-back words, no bubble
    mv = 1'b1; md = 32'h11223344;
    step();
    md = 32'h55667788;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) mv = 1'b0;
      chk("t2_sv", sv_l, 1);
      chk("t2_sd", sd_l, e2[k]);
      chk("t2_mr", mr_l, r2[k]);
      step();
    end
    chk("t2_idle", sv_l, 0);

    // Stall on beat 2 for three cycles
    nv = 0;
    mv = 1'b1; md = 32'hDEADBEEF;
    step();
    mv = 1'b0;
    chk("t3_b0", sd_l, 8'hEF); nv += int'(sv_l); step();
    chk("t3_b1", sd_l, 8'hBE); nv += int'(sv_l); step();
    sr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_sd", sd_l, 8'hAD);
      chk("t3_stall_mr", mr_l, 0);
      nv += int'(sv_l);
      step();
    end
    sr = 1'b1;
    chk("t3_b2", sd_l, 8'hAD); nv += int'(sv_l); step();
    chk("t3_b3", sd_l, 8'hDE); nv += int'(sv_l); step();
    nv += int'(sv_l);
    chk("t3_word_time", nv, 7);

    // MSB-first instance
    mv = 1'b1; md = 32'h01020304;
    step();
    mv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_sd_m", sd_m, e4[i]);
      chk("t4_sd_l", sd_l, e4[3-i]);
      step();
    end

    // Asynchronous reset mid-word
    mv = 1'b1; md = 32'hCAFEF00D;
    step();
    mv = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_sv", sv_l, 0);
    chk("t5_rst_sd", sd_l, 0);
    chk("t5_rst_sv_m", sv_m, 0);
    chk("t5_rst_sd_m", sd_m, 0);
    q_l.delete(); q_m.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t5_mr", mr_l, 1);
    mv = 1'b1; md = 32'h00000055;
    step();
    mv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_sd", sd_l, e5[i]);
      step();
    end

    // Random traffic against the scoreboard
    sent = 0; cyc = 0;
    while (sent < NWORDS && cyc < 60000) begin
      if (!mv && $urandom_range(3) != 0) begin
        mv = 1'b1; md = $urandom;
      end
      sr = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = mv && mr_l;
      step();
      cyc++;
      if (acc) begin
        sent++;
        mv = 1'b0;
        if ($urandom_range(1) == 1) begin
          mv = 1'b1; md = $urandom;
        end
      end
    end
    chk("rand_sent", sent, NWORDS);
    mv = 1'b0; sr = 1'b1;
    for (int i = 0; i < 20 && (q_l.size() != 0 || q_m.size() != 0); i++) step();
    step();
    chk("drain_l", q_l.size(), 0);
    chk("drain_m", q_m.size(), 0);
    chk("drain_sv", sv_l, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
